// File: rtl/m_div_unit.sv
// Radix-2 restoring divider for the M extension: DIV/DIVU/REM/REMU.
// Takes 32 CALC cycles plus one sign-fix cycle. Divide-by-zero and signed overflow finish in one cycle.
module m_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_next;
  logic [4:0]      count;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic            neg_q, neg_r, sel_rem;

  logic            accept, is_signed, div_zero, overflow;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   shifted, diff;

  assign accept    = (state == IDLE) && start && funct3[2];
  assign is_signed = ~funct3[0];
  assign div_zero  = (rs2 == '0);
  assign overflow  = is_signed && (rs1 == INT_MIN) && (rs2 == '1);
  assign abs1      = (is_signed && rs1[XLEN-1]) ? -rs1 : rs1;
  assign abs2      = (is_signed && rs2[XLEN-1]) ? -rs2 : rs2;

  // The shifted partial remainder can need XLEN+1 bits on unsigned operands,
  // so the trial subtraction runs one bit wider. Its sign bit selects restore.
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign diff      = shifted - {1'b0, dvsr_q};

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  always_comb begin
    // NOTE: default first, so that no path through the case can infer a latch.
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (div_zero || overflow) ? DONE : CALC;
      CALC: if (count == 5'd0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments in clocked blocks keep every register
  // reading the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sel_rem <= funct3[1];
          neg_q   <= is_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
          neg_r   <= is_signed && rs1[XLEN-1];
          rem_q   <= '0;
          quo_q   <= abs1;
          dvsr_q  <= abs2;
          count   <= 5'd31;
          if (div_zero)      result <= funct3[1] ? rs1 : '1;
          else if (overflow) result <= funct3[1] ? '0 : INT_MIN;
        end
        CALC: begin
          rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
          count <= count - 5'd1;
        end
        FIX: begin
          if (sel_rem) result <= neg_r ? -rem_q : rem_q;
          else         result <= neg_q ? -quo_q : quo_q;
        end
        default: ;
      endcase
    end
  end

endmodule
